input_module: RTL
=================

INPUT_MODULE -- requirements
Module: input_module

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable clock cycles required to accept a pushbutton level change.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (pushbutton-driven).
REQ-004 key_enter  input  1  raw pushbutton, active-low, asynchronous to clock, bouncy.
REQ-005 key_clear  input  1  raw pushbutton, active-low, asynchronous to clock, bouncy.
REQ-006 switches  input  16  raw slide-switch value, sampled on an accepted enter press.
REQ-007 data_out  output  32  assembled word {high half, low half}.
REQ-008 data_valid  output  1  data_out holds a complete, unconsumed word.
REQ-009 data_ack  input  1  processor consumption strobe, sampled only while data_valid=1.
REQ-010 half_flag  output  1  low half captured; awaiting high half (LED indicator).
REQ-011 overrun  output  1  sticky: an enter press occurred while a word was pending.

Function
REQ-012 Each key passes through a 2-FF synchronizer, with synchronizer flops preset to 1 (released).
REQ-013 The debounced level changes only after the synchronized sample differs from it for DEBOUNCE_CYCLES consecutive cycles; any matching sample restarts the count at 0.
REQ-014 A press event is a registered pulse, high for exactly one cycle, in the cycle after the debounced level goes 1->0; release produces no event.
REQ-015 Press-event latency from a clean raw falling edge is fixed at DEBOUNCE_CYCLES+3 cycles; holding a key produces exactly one event.
REQ-016 FSM states: IDLE, LOW_HELD, VALID.
- IDLE, enter event: latch switches into low half; go to LOW_HELD.
- LOW_HELD, enter event: latch switches into high half; drive data_out={high,low} and data_valid=1 in the next cycle; go to VALID.
- VALID, data_ack=1: data_valid=0 in the next cycle; go to IDLE.
- VALID, enter event: ignored for data; overrun set to 1.
REQ-017 data_out shall remain constant throughout VALID and stay unchanged after acknowledgement until the next completed word.
REQ-018 half_flag=1 exactly while in LOW_HELD.
REQ-019 A clear event in any state: go to IDLE; data_valid, half_flag and overrun go to 0 and the partial low half is discarded; data_out is retained.
REQ-020 Clear has priority over both enter and data_ack in the same cycle.
REQ-021 In VALID, simultaneous data_ack and enter: perform the acknowledge and set overrun; the press does not start a new word.
REQ-022 data_ack outside VALID has no effect.
REQ-023 overrun is cleared only by clear or reset.

Reset
REQ-024 While reset=0 (asynchronous), state=IDLE and data_out=0, data_valid=0, half_flag=0, overrun=0.
REQ-025 While reset=0, debounced levels=1, debounce counters=0 and press pulses=0.
REQ-026 Deassertion of reset produces no spurious press event, even with a key held.
REQ-027 Reset asserted mid-word discards the partial capture.

Structure
REQ-028 Shared package input_pkg holds the FSM state enumeration and the default DEBOUNCE_CYCLES constant.
REQ-029 One sub-module, debouncer, shall contain the synchronizer, the counter and the press-pulse logic, and be instantiated twice (enter, clear).
REQ-030 The top-level processor shall connect data_out, data_valid and data_ack as the processor's memory-mapped input port.

Verification
REQ-031 DEBOUNCE_CYCLES=4, enter pressed with 3 bounces of 2 cycles each, then held -> exactly one press pulse, arriving 7 cycles after the final stable edge.
REQ-032 Two presses with switches 0x1234 then 0xABCD -> half_flag=1 between the presses; then data_out=0xABCD1234, data_valid=1; data_ack for 1 cycle -> data_valid=0 next cycle and data_out unchanged.
REQ-033 In VALID, enter pressed with switches 0xFFFF -> data_out stays 0xABCD1234 and overrun=1; clear pressed -> overrun=0, state IDLE.
REQ-034 Low half 0x0001 captured, then clear and data_ack in the same cycle -> half_flag=0, data_valid=0; next two presses 0x0002, 0x0003 -> data_out=0x00030002.
REQ-035 reset asserted while in LOW_HELD, and separately in VALID -> all outputs 0 immediately; key held through reset release -> no press event.

Source files
------------

// File: rtl/input_pkg.sv
// Shared definitions for the pushbutton/switch word-entry block: FSM state
// encoding and the default debounce interval.
package input_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StLowHeld = 2'd1;
  localparam state_t StValid   = 2'd2;

  localparam int unsigned DebounceCyclesDefault = 32'd1000000;

endpackage

// File: rtl/debouncer.sv
// Active-low pushbutton conditioner: 2-FF synchronizer, stability counter and a
// one-cycle registered press pulse on each accepted 1->0 debounced transition.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_db;
  logic            r_db_prev;
  logic            r_press;
  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_init;
  logic            r_armed;
  logic            w_diff;
  logic            w_flip;

  always_comb begin
    w_diff = r_sync2 ^ r_db;
    w_flip = w_diff && (r_cnt == CntLast);
  end

  // r_armed stays low until the key is seen released after reset, so a key
  // held through reset release never yields a press pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_db      <= 1'b1;
      r_db_prev <= 1'b1;
      r_press   <= 1'b0;
      r_cnt     <= '0;
      r_init    <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_sync1   <= i_key_n;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      r_press   <= r_armed & r_db_prev & ~r_db;
      r_init    <= {r_init[0], 1'b1};
      if (r_init[1] && r_sync2) begin
        r_armed <= 1'b1;
      end
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt <= '0;
        r_db  <= ~r_db;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/input_module.sv
// Two-press word assembler: switches captured as low then high half, presented
// to the processor as a valid word until acknowledged.
module input_module
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_enter,
  input  logic        key_clear,
  input  logic [15:0] switches,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        data_ack,
  output logic        half_flag,
  output logic        overrun
);

  logic        w_enter;
  logic        w_clear;
  state_t      r_state;
  logic [15:0] r_low;
  logic [31:0] r_data;
  logic        r_overrun;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter (
    .i_clk  (clock),
    .i_rst_n(reset),
    .i_key_n(key_enter),
    .o_press(w_enter)
  );

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear (
    .i_clk  (clock),
    .i_rst_n(reset),
    .i_key_n(key_clear),
    .o_press(w_clear)
  );

  // Clear outranks enter and ack; data_out survives clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_low     <= '0;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else if (w_clear) begin
      r_state   <= StIdle;
      r_low     <= '0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_enter) begin
            r_low   <= switches;
            r_state <= StLowHeld;
          end
        end
        StLowHeld: begin
          if (w_enter) begin
            r_data  <= {switches, r_low};
            r_state <= StValid;
          end
        end
        StValid: begin
          if (w_enter) begin
            r_overrun <= 1'b1;
          end
          if (data_ack) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = (r_state == StValid);
  assign half_flag  = (r_state == StLowHeld);
  assign overrun    = r_overrun;

endmodule
